// File: rtl/dlx_instr_encoder_if.sv
// Descriptor-in / instruction-out handshake bundle for dlx_instr_encoder.
// master: host or test sequencer side; slave: the encoder.
interface dlx_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_func;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_opcode, in_func, in_rs1, in_rs2, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_opcode, in_func, in_rs1, in_rs2, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/dlx_instr_encoder.sv
// DLX instruction encoder: builds R/I/J-type words from field descriptors and
// buffers them in a DEPTH-entry FIFO toward the fetch stage.
// Optional feature macro: DLX_ENC_ILLEGAL_CHECK_EN -- when defined, opcodes
// 0x30-0x3F are accepted but dropped and reported via err_illegal/err_count;
// when undefined they are encoded as I-type and the error outputs are 0.
module dlx_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dlx_instr_encoder_if.slave       bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_illegal,
  output logic [CNTW-1:0]          err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   enc;
  logic          illegal;
  logic          accept;
  logic          push;
  logic          pop;

  assign bus.in_ready  = (count < DEPTH_C) & ~flush;
  assign bus.out_valid = (count != '0) & ~flush;
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 32'h0;

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & ~illegal;
  assign pop    = bus.out_valid & bus.out_ready;

  // Format selection by opcode; anything not R or J falls through to I-type.
  always_comb begin
    enc = {bus.in_opcode, bus.in_rs1, bus.in_rd, bus.in_imm[15:0]};
    if (bus.in_opcode == 6'h00 || bus.in_opcode == 6'h01)
      enc = {bus.in_opcode, bus.in_rs1, bus.in_rs2, bus.in_rd, 5'b0, bus.in_func};
    else if (bus.in_opcode == 6'h02 || bus.in_opcode == 6'h03 ||
             bus.in_opcode == 6'h10 || bus.in_opcode == 6'h11)
      enc = {bus.in_opcode, bus.in_imm};
  end

  // Storage array; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc;
  end

  // Pointer and occupancy tracking; reset and flush both clear everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef DLX_ENC_ILLEGAL_CHECK_EN
  assign illegal = (bus.in_opcode[5:4] == 2'b11);

  // Rejected-descriptor pulse and saturating counter; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= accept & illegal;
      if (accept && illegal && (err_count != '1))
        err_count <= err_count + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign illegal     = 1'b0;
  assign err_illegal = 1'b0;
  assign err_count   = '0;
`endif

endmodule

// File: doc/dlx_instr_encoder.md
# dlx_instr_encoder

Assembles 32-bit DLX instruction words from decoded field descriptors, the inverse of the control decoder. Words are buffered in a small FIFO and presented to the fetch stage through a valid/ready handshake. It is the injection path for debug and self-test programs: a host or test sequencer supplies opcode, function, register and immediate fields, and the block emits correctly formatted R-, I- or J-type words.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNTW, 8, width of the illegal-opcode counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  descriptor present.
- in_ready  out  1  block can accept a descriptor this cycle.
- in_opcode  in  6  primary opcode.
- in_func  in  6  function code; used for R-type only.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2; used for R-type only.
- in_rd  in  5  destination register.
- in_imm  in  26  immediate; low 16 bits for I-type, all 26 for J-type.
- flush  in  1  discard all buffered words.
- out_valid  out  1  word available.
- out_ready  in  1  fetch consumes the word.
- out_instr  out  32  instruction word; bit 31 is the MSB of the opcode.
- count  out  log2(DEPTH)+1  FIFO occupancy.
- err_illegal  out  1  one-cycle pulse when a descriptor is rejected.
- err_count  out  CNTW  saturating count of rejected descriptors.

## Operation
- Format class by in_opcode:
  - R-type: 0x00, 0x01.
  - J-type: 0x02, 0x03, 0x10, 0x11.
  - I-type: 0x04–0x0F and 0x12–0x2F.
  - Illegal: 0x30–0x3F.
- Word layout:
  - R-type: {opcode, rs1, rs2, rd, 5'b0, func}.
  - I-type: {opcode, rs1, rd, imm[15:0]}. rd goes in bits 20:16.
  - J-type: {opcode, imm[25:0]}.
- Transfers:
  - Accept: a descriptor is accepted when in_valid & in_ready.
  - Push: an accepted legal descriptor is encoded and written to the FIFO tail.
  - Pop: occurs when out_valid & out_ready.
- FIFO pointers: read/write pointers of log2(DEPTH) bits wrap modulo DEPTH. count holds the exact occupancy, 0..DEPTH.
- Full and empty:
  - in_ready = (count < DEPTH) & ~flush.
  - out_valid = (count != 0) & ~flush.
- Full with simultaneous pop: in_ready stays 0. There is no same-cycle pass-through. The pop proceeds and the push is retried next cycle.
- Not full and not empty, simultaneous push and pop: both proceed and count is unchanged.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - The next cycle has count=0 and both pointers at 0.
  - err_count is unaffected.
- Field use: unused fields are ignored; bits that are not encoded from an input field are 0.
- out_instr: shows the FIFO head while out_valid=1 and is held stable until popped. When empty it reads 32'h0.

## Timing
- Reset values:
  - count=0 and pointers=0.
  - out_valid=0 and in_ready=1.
  - out_instr=0.
  - err_illegal=0 and err_count=0.
- Latency: a descriptor accepted in cycle N appears on out_instr with out_valid=1 in cycle N+1 if the FIFO was empty. Otherwise it appears behind the older entries.
- Throughput: one push and one pop per cycle.
- Reset mid-transfer: rst dominates flush and all handshakes. Buffered words are lost and the accepting handshake of that cycle is dropped.
- err_illegal: asserts in the cycle after acceptance and lasts exactly one cycle.
- err_count: saturates at 2^CNTW−1.

## Configuration
- DLX_ENC_ILLEGAL_CHECK_EN defined:
  - Illegal opcodes (0x30–0x3F) are accepted, subject to the same in_ready, but never written to the FIFO.
  - err_illegal pulses and err_count increments.
- DLX_ENC_ILLEGAL_CHECK_EN undefined:
  - 0x30–0x3F are encoded as I-type and pushed normally.
  - err_illegal and err_count are tied to 0.

## Test plan
- Reset, then push {op=0x00, rs1=1, rs2=2, rd=3, func=0x20} with out_ready=1 → out_instr=0x00221820 one cycle later; count returns to 0.
- Push I-type {op=0x08, rs1=4, rd=5, imm=0xFFFF} then J-type {op=0x03, imm=0x0000010}, with out_ready=0 → count=2. Release out_ready → outputs 0x2085FFFF then 0x0C000010 in order.
- Fill DEPTH=4 with out_ready=0 → in_ready=0 at count=4. Assert out_ready and in_valid together → one pop; the push stalls one cycle; order is preserved across pointer wrap.
- Flush with count=3 while in_valid=1 and out_ready=1 → no push or pop that cycle; count=0 and out_valid=0 next cycle.
- With DLX_ENC_ILLEGAL_CHECK_EN: push op=0x3A → no FIFO write; err_illegal pulses once; err_count=1. Without it: out_instr carries opcode 0x3A in I-format.
- Assert rst mid-stream with count=2 and a handshake active → next cycle all outputs are at reset values.
